// File: rtl/mpu_bram_arbiter.sv
// mpu_bram_arbiter: shares the data-side BRAM port between the MPU data bus and
// the APF bridge, holding the MPU in reset while the bridge owns the memory.
module mpu_bram_arbiter #(
  parameter int ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bridge_lock,
  output logic                 mpu_hold,
  input  logic                 mpu_request,
  input  logic                 mpu_write,
  input  logic [23:0]          mpu_address,
  input  logic [3:0]           mpu_mask,
  input  logic [31:0]          mpu_wdata,
  output logic [31:0]          mpu_rdata,
  output logic                 mpu_valid,
  input  logic                 br_rd,
  input  logic                 br_wr,
  input  logic [23:0]          br_addr,
  input  logic [31:0]          br_wdata,
  output logic [31:0]          br_rdata,
  output logic                 br_done,
  output logic                 br_busy,
  output logic                 br_overrun,
  output logic                 mem_request,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [3:0]           mem_mask,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic OWN_MPU = 1'b0;
  localparam logic OWN_BR  = 1'b1;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic                   mpu_hold_q, mpu_hold_d;
  logic                   pend_q, pend_d;
  logic                   pend_wr_q, pend_wr_d;
  logic [ADDR_BITS-1:0]   pend_addr_q, pend_addr_d;
  logic [31:0]            pend_wdata_q, pend_wdata_d;
  logic                   overrun_q, overrun_d;
  logic [31:0]            br_rdata_q, br_rdata_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]             mem_mask_q, mem_mask_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;

  logic                   in_resp;
  logic                   slot_done;
  logic                   slot_busy;
  logic                   mpu_served;
  logic                   mpu_inflight;
  logic                   mpu_elig;
  logic                   br_elig;
  logic                   arb_window;
  logic                   grant_mpu;
  logic                   grant_br;
  logic                   br_cmd;
  logic                   unused_addr_bits;

  // Completion contract: mpu_valid and br_done are single-cycle pulses in the
  // RESP cycle. The MPU holds mpu_request until mpu_valid; a request still high
  // at the edge ending that cycle is treated as a fresh access. Bridge commands
  // are fire-and-forget pulses accepted only while br_busy is low.
  assign in_resp      = (state_q == ST_RESP);
  assign slot_done    = in_resp && (owner_q == OWN_BR);
  assign mpu_served   = in_resp && (owner_q == OWN_MPU);
  assign mpu_inflight = (state_q != ST_IDLE) && (owner_q == OWN_MPU);
  assign slot_busy    = pend_q && !slot_done;
  assign br_cmd       = br_rd || br_wr;

  assign mpu_elig   = mpu_request && !mpu_hold_q && !bridge_lock && !mpu_served;
  assign br_elig    = pend_q && !slot_done;
  assign arb_window = (state_q == ST_IDLE) || in_resp;
  assign grant_mpu  = arb_window && mpu_elig && (!br_elig || (last_grant_q == OWN_BR));
  assign grant_br   = arb_window && br_elig && !grant_mpu;

  assign unused_addr_bits = ^{mpu_address[23:ADDR_BITS+2], mpu_address[1:0],
                              br_addr[23:ADDR_BITS+2], br_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_MPU;
      last_grant_q <= OWN_BR;
      mpu_hold_q   <= 1'b1;
      pend_q       <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      overrun_q    <= 1'b0;
      br_rdata_q   <= '0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_mask_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mpu_hold_q   <= mpu_hold_d;
      pend_q       <= pend_d;
      pend_wr_q    <= pend_wr_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      overrun_q    <= overrun_d;
      br_rdata_q   <= br_rdata_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_mask_q   <= mem_mask_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mpu_hold_d   = mpu_hold_q;
    pend_d       = pend_q;
    pend_wr_d    = pend_wr_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    overrun_d    = overrun_q;
    br_rdata_d   = br_rdata_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_mask_d   = mem_mask_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE:  state_d = (grant_mpu || grant_br) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = (grant_mpu || grant_br) ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (grant_mpu) begin
      owner_d      = OWN_MPU;
      last_grant_d = OWN_MPU;
      mem_wr_d     = mpu_write;
      mem_addr_d   = mpu_address[ADDR_BITS+1:2];
      mem_mask_d   = mpu_write ? mpu_mask : 4'hF;
      mem_wdata_d  = mpu_wdata;
    end else if (grant_br) begin
      owner_d      = OWN_BR;
      last_grant_d = OWN_BR;
      mem_wr_d     = pend_wr_q;
      mem_addr_d   = pend_addr_q;
      mem_mask_d   = 4'hF;
      mem_wdata_d  = pend_wdata_q;
    end

    // The slot may be refilled on the same edge it retires, since br_busy
    // already reads low during the br_done cycle.
    if (br_cmd && !slot_busy) begin
      pend_d       = 1'b1;
      pend_wr_d    = br_wr;
      pend_addr_d  = br_addr[ADDR_BITS+1:2];
      pend_wdata_d = br_wdata;
    end else if (slot_done) begin
      pend_d = 1'b0;
    end
    if (br_cmd && slot_busy) begin
      overrun_d = 1'b1;
    end

    if (slot_done && !mem_wr_q) begin
      br_rdata_d = mem_rdata;
    end

    if (bridge_lock && !mpu_inflight) begin
      mpu_hold_d = 1'b1;
    end else if (!bridge_lock && (state_q == ST_IDLE) && !pend_q) begin
      mpu_hold_d = 1'b0;
    end
  end

  always_comb begin
    mem_request = (state_q == ST_ISSUE);
    mem_write   = (state_q == ST_ISSUE) && mem_wr_q;
    mem_address = mem_addr_q;
    mem_mask    = mem_mask_q;
    mem_wdata   = mem_wdata_q;
    mpu_valid   = mpu_served;
    mpu_rdata   = mpu_served ? mem_rdata : 32'h0;
    br_done     = slot_done;
    br_busy     = slot_busy;
    br_rdata    = (slot_done && !mem_wr_q) ? mem_rdata : br_rdata_q;
    br_overrun  = overrun_q;
    mpu_hold    = mpu_hold_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_mpu_bram_arbiter.sv
// tb_mpu_bram_arbiter: directed and randomized accesses checked against a
// word-level memory model and the documented access latencies.
module tb_mpu_bram_arbiter;
  localparam int ADDR_BITS = 14;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 bridge_lock;
  logic                 mpu_hold;
  logic                 mpu_request;
  logic                 mpu_write;
  logic [23:0]          mpu_address;
  logic [3:0]           mpu_mask;
  logic [31:0]          mpu_wdata;
  logic [31:0]          mpu_rdata;
  logic                 mpu_valid;
  logic                 br_rd;
  logic                 br_wr;
  logic [23:0]          br_addr;
  logic [31:0]          br_wdata;
  logic [31:0]          br_rdata;
  logic                 br_done;
  logic                 br_busy;
  logic                 br_overrun;
  logic                 mem_request;
  logic                 mem_write;
  logic [ADDR_BITS-1:0] mem_address;
  logic [3:0]           mem_mask;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata = '0;
  logic [1:0]           dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt  = 0;
  int valid_cnt = 0;

  always #5 clk = ~clk;

  mpu_bram_arbiter #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset(reset), .bridge_lock(bridge_lock), .mpu_hold(mpu_hold),
    .mpu_request(mpu_request), .mpu_write(mpu_write), .mpu_address(mpu_address),
    .mpu_mask(mpu_mask), .mpu_wdata(mpu_wdata), .mpu_rdata(mpu_rdata),
    .mpu_valid(mpu_valid), .br_rd(br_rd), .br_wr(br_wr), .br_addr(br_addr),
    .br_wdata(br_wdata), .br_rdata(br_rdata), .br_done(br_done), .br_busy(br_busy),
    .br_overrun(br_overrun), .mem_request(mem_request), .mem_write(mem_write),
    .mem_address(mem_address), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // BRAM port A: erased to all ones, registered read, byte-masked write.
  logic [31:0] bram [int];
  logic [31:0] bram_cur;
  always @(posedge clk) begin
    if (mem_request) begin
      bram_cur = bram.exists(int'(mem_address)) ? bram[int'(mem_address)] : 32'hFFFF_FFFF;
      mem_rdata <= bram_cur;
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) bram_cur[8*b +: 8] = mem_wdata[8*b +: 8];
        bram[int'(mem_address)] = bram_cur;
      end
    end
  end

  always @(negedge clk) begin
    if (br_done) done_cnt++;
    if (mpu_valid) valid_cnt++;
  end

  // Reference memory: what software expects to have stored, word by word.
  logic [31:0] ref_mem [int];

  function automatic int word_of(input logic [23:0] a);
    return (int'(a) / 4) % DEPTH;
  endfunction

  function automatic logic [31:0] ref_read(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] bram_read(input int w);
    if (bram.exists(w)) return bram[w];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic ref_write(input int w, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] v;
    v = ref_read(w);
    for (int b = 0; b < 4; b++)
      if (m[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[w] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mpu_op(input logic wr, input logic [23:0] a, input logic [3:0] m,
                        input logic [31:0] d, input string tag,
                        output logic [31:0] rd, output logic [31:0] seen_addr);
    int lat;
    logic got, seen_wr;
    logic [3:0] seen_mask;
    mpu_request = 1'b1; mpu_write = wr; mpu_address = a; mpu_mask = m; mpu_wdata = d;
    lat = 0; got = 1'b0; rd = '0; seen_addr = 32'hFFFF_FFFF; seen_wr = 1'bx; seen_mask = 'x;
    while (!got && lat < 10) begin
      tick();
      lat++;
      if (mem_request) begin
        seen_addr = 32'(mem_address); seen_wr = mem_write; seen_mask = mem_mask;
      end
      if (mpu_valid) begin
        got = 1'b1; rd = mpu_rdata;
      end
    end
    mpu_request = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_addr"}, seen_addr, 32'(word_of(a)));
    check({tag, "_wr"}, 32'(seen_wr), 32'(wr));
    if (wr) begin
      check({tag, "_mask"}, 32'(seen_mask), 32'(m));
      ref_write(word_of(a), d, m);
    end else begin
      check({tag, "_rdata"}, rd, ref_read(word_of(a)));
    end
    tick();
    check({tag, "_pulse"}, 32'(mpu_valid), 32'd0);
  endtask

  task automatic br_op(input logic wr, input logic [23:0] a, input logic [31:0] d,
                       input string tag);
    int lat;
    logic [31:0] seen_addr;
    logic [3:0] seen_mask;
    br_wr = wr; br_rd = !wr; br_addr = a; br_wdata = d;
    seen_addr = 32'hFFFF_FFFF; seen_mask = 'x;
    tick();
    br_wr = 1'b0; br_rd = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 32'(br_busy), 32'd1);
    while (!br_done && lat < 12) begin
      tick();
      lat++;
      if (mem_request) begin
        seen_addr = 32'(mem_address); seen_mask = mem_mask;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_busy_fall"}, 32'(br_busy), 32'd0);
    check({tag, "_addr"}, seen_addr, 32'(word_of(a)));
    check({tag, "_mask"}, 32'(seen_mask), 32'hF);
    tick();
    check({tag, "_pulse"}, 32'(br_done), 32'd0);
    if (wr) ref_write(word_of(a), d, 4'hF);
    else check({tag, "_rdata"}, br_rdata, ref_read(word_of(a)));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, sa;
    logic [31:0] upl [8];
    int d0, v0, n, bad;
    logic hold_low;

    reset = 1'b1; bridge_lock = 1'b0;
    mpu_request = 1'b0; mpu_write = 1'b0; mpu_address = '0; mpu_mask = '0; mpu_wdata = '0;
    br_rd = 1'b0; br_wr = 1'b0; br_addr = '0; br_wdata = '0;
    repeat (3) tick();
    check("rst_hold", 32'(mpu_hold), 32'd1);
    check("rst_mem_request", 32'(mem_request), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mpu_valid", 32'(mpu_valid), 32'd0);
    check("rst_br_done", 32'(br_done), 32'd0);
    check("rst_br_busy", 32'(br_busy), 32'd0);
    check("rst_br_overrun", 32'(br_overrun), 32'd0);
    check("rst_br_rdata", br_rdata, 32'd0);
    reset = 1'b0;
    tick();
    check("hold_release", 32'(mpu_hold), 32'd0);

    // MPU write then read-back into an erased word, then an aliased address.
    mpu_op(1'b1, 24'h000010, 4'b0011, 32'hA5A5_1234, "mpu_wr", rd, sa);
    check("mpu_wr_word", sa, 32'd4);
    mpu_op(1'b0, 24'h000010, 4'h0, 32'h0, "mpu_rd", rd, sa);
    check("mpu_rd_value", rd, 32'hFFFF_1234);
    mpu_op(1'b0, 24'h010004, 4'h0, 32'h0, "wrap", rd, sa);
    check("wrap_word", sa, 32'd1);

    // Upload under lock.
    bridge_lock = 1'b1;
    tick();
    check("lock_latency", 32'(mpu_hold), 32'd1);
    d0 = done_cnt; hold_low = 1'b0;
    for (int k = 0; k < 8; k++) begin
      upl[k] = $urandom;
      br_wr = 1'b1; br_addr = 24'(4 * k); br_wdata = upl[k];
      tick();
      if (!mpu_hold) hold_low = 1'b1;
      br_wr = 1'b0;
      repeat (2) begin
        tick();
        if (!mpu_hold) hold_low = 1'b1;
      end
      ref_write(k, upl[k], 4'hF);
    end
    repeat (4) begin
      tick();
      if (!mpu_hold) hold_low = 1'b1;
    end
    check("upl_done_count", 32'(done_cnt - d0), 32'd8);
    check("upl_overrun", 32'(br_overrun), 32'd0);
    check("upl_hold", 32'(hold_low), 32'd0);
    for (int k = 0; k < 8; k++) check("upl_word", bram_read(k), upl[k]);
    bridge_lock = 1'b0;
    repeat (2) tick();
    check("unlock_hold", 32'(mpu_hold), 32'd0);

    // Contention: last grant went to the bridge, so the MPU wins first.
    br_rd = 1'b1; br_addr = 24'h000100;
    tick();
    br_rd = 1'b0;
    check("ct_busy", 32'(br_busy), 32'd1);
    mpu_request = 1'b1; mpu_write = 1'b0; mpu_address = 24'h000010;
    tick();
    check("ct_g1_req", 32'(mem_request), 32'd1);
    check("ct_g1_mpu", 32'(mem_address), 32'(word_of(24'h000010)));
    tick();
    check("ct_v1", 32'(mpu_valid), 32'd1);
    check("ct_v1_data", mpu_rdata, ref_read(word_of(24'h000010)));
    mpu_address = 24'h000014;
    tick();
    check("ct_g2_req", 32'(mem_request), 32'd1);
    check("ct_g2_br", 32'(mem_address), 32'(word_of(24'h000100)));
    check("ct_g2_novalid", 32'(mpu_valid), 32'd0);
    tick();
    check("ct_done1", 32'(br_done), 32'd1);
    tick();
    check("ct_g3_req", 32'(mem_request), 32'd1);
    check("ct_g3_mpu", 32'(mem_address), 32'(word_of(24'h000014)));
    check("ct_rdata1", br_rdata, ref_read(word_of(24'h000100)));
    br_rd = 1'b1; br_addr = 24'h000000;
    tick();
    br_rd = 1'b0;
    check("ct_v2", 32'(mpu_valid), 32'd1);
    check("ct_v2_data", mpu_rdata, ref_read(word_of(24'h000014)));
    check("ct_busy2", 32'(br_busy), 32'd1);
    mpu_request = 1'b0;
    tick();
    check("ct_g4_req", 32'(mem_request), 32'd1);
    check("ct_g4_br", 32'(mem_address), 32'(word_of(24'h000000)));
    tick();
    check("ct_done2", 32'(br_done), 32'd1);
    tick();
    check("ct_rdata2", br_rdata, ref_read(0));

    // Randomized serial traffic from both masters over an aliased window.
    for (int i = 0; i < 30; i++) begin
      int hi, w, lo;
      logic [23:0] a;
      hi = $urandom_range(0, 255); w = $urandom_range(0, 31); lo = $urandom_range(0, 3);
      a = 24'(hi * 65536 + w * 4 + lo);
      if ($urandom_range(0, 1) == 1)
        mpu_op(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, "rnd_mpu", rd, sa);
      else
        br_op(1'($urandom_range(0, 1)), a, $urandom, "rnd_br");
    end

    // Overrun: second command while busy is dropped, the first completes.
    d0 = done_cnt;
    br_wr = 1'b1; br_addr = 24'h000200; br_wdata = 32'h1357_9BDF;
    tick();
    check("ov_busy", 32'(br_busy), 32'd1);
    br_addr = 24'h000204; br_wdata = 32'h2468_ACE0;
    tick();
    br_wr = 1'b0;
    check("ov_set", 32'(br_overrun), 32'd1);
    n = 0;
    while (!br_done && n < 10) begin
      tick();
      n++;
    end
    check("ov_done", 32'(br_done), 32'd1);
    ref_write(word_of(24'h000200), 32'h1357_9BDF, 4'hF);
    repeat (4) tick();
    check("ov_sticky", 32'(br_overrun), 32'd1);
    check("ov_one_done", 32'(done_cnt - d0), 32'd1);

    // Lock arriving mid-access: the access finishes, then the hold rises.
    mpu_request = 1'b1; mpu_write = 1'b0; mpu_address = 24'h000010;
    tick();
    check("lk_issue", 32'(mem_request), 32'd1);
    bridge_lock = 1'b1;
    tick();
    check("lk_valid", 32'(mpu_valid), 32'd1);
    check("lk_data", mpu_rdata, ref_read(4));
    check("lk_hold_inflight", 32'(mpu_hold), 32'd0);
    mpu_request = 1'b0;
    n = 0;
    while (!mpu_hold && n < 5) begin
      tick();
      n++;
    end
    check("lk_hold_rise", 32'(mpu_hold), 32'd1);
    bridge_lock = 1'b0;
    repeat (2) tick();
    check("lk_release", 32'(mpu_hold), 32'd0);

    // Reset during ISSUE abandons the read and the pending bridge write.
    v0 = valid_cnt; d0 = done_cnt;
    mpu_request = 1'b1; mpu_write = 1'b0; mpu_address = 24'h000020;
    br_wr = 1'b1; br_addr = 24'h000300; br_wdata = 32'hDEAD_BEEF;
    tick();
    br_wr = 1'b0;
    check("rm_issue", 32'(mem_request), 32'd1);
    reset = 1'b1; mpu_request = 1'b0;
    tick();
    check("rm_no_valid", 32'(mpu_valid), 32'd0);
    check("rm_mem_request", 32'(mem_request), 32'd0);
    check("rm_hold", 32'(mpu_hold), 32'd1);
    check("rm_busy", 32'(br_busy), 32'd0);
    check("rm_overrun_clr", 32'(br_overrun), 32'd0);
    reset = 1'b0;
    repeat (6) tick();
    check("rm_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("rm_done_cnt", 32'(done_cnt - d0), 32'd0);

    bad = 0;
    for (int w = 0; w < 256; w++)
      if (bram_read(w) !== ref_read(w)) bad++;
    check("mem_final_mismatches", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
